// File: rtl/icmp_encode_stream.sv
// icmp_encode_stream: prepends a 4- or 8-byte ICMP header to a ready/valid payload stream.
// Latency: first header word 1 clk after start; each payload word 1 clk after acceptance.
// Backpressure: output word held while out_ready is low; in_ready = out_ready | ~out_valid in payload phase.
module icmp_encode_stream #(
  parameter int AVL_SIZE  = 8,
  parameter int ECHO_HDR  = 0,
  parameter int BYTE_SIZE = 8,
  parameter int EMPTY_W   = ((AVL_SIZE / BYTE_SIZE) > 1) ? $clog2(AVL_SIZE / BYTE_SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          icmp_type,
  input  logic [7:0]          code,
  input  logic [15:0]         checksum,
  input  logic [15:0]         identifier,
  input  logic [15:0]         icmp_sequence,
  input  logic [AVL_SIZE-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_eop,
  input  logic [EMPTY_W-1:0]  in_empty,
  output logic                in_ready,
  output logic [AVL_SIZE-1:0] out_data,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  output logic [EMPTY_W-1:0]  out_empty,
  input  logic                out_ready,
  output logic                busy
);

  localparam int HDR_BYTES = 4 + 4 * ECHO_HDR;
  localparam int HDR_BITS  = HDR_BYTES * BYTE_SIZE;
  localparam int HDR_WORDS = HDR_BITS / AVL_SIZE;
  localparam int CNT_W     = $clog2(HDR_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t              state;
  logic [HDR_BITS-1:0] hdr_fields;
  logic [HDR_BITS-1:0] hdr_reg;
  logic [HDR_BITS-1:0] hdr_shift;
  logic [CNT_W-1:0]    cnt;
  logic                eop_taken;   // eop word accepted, waiting for it to leave
  logic                xfer;
  logic                accept;

  // Header layout is MSB-first so the first byte on the wire is the ICMP type.
  generate
    if (ECHO_HDR != 0) begin : g_echo
      assign hdr_fields = {icmp_type, code, checksum, identifier, icmp_sequence};
    end else begin : g_plain
      logic unused_echo;
      assign unused_echo = ^{identifier, icmp_sequence};
      assign hdr_fields  = {icmp_type, code, checksum};
    end
  endgenerate

  assign hdr_shift = hdr_reg << AVL_SIZE;
  assign xfer      = out_valid & out_ready;
  // Only take payload when the output register is free or emptying this cycle.
  assign in_ready  = (state == PAY) & ~eop_taken & (out_ready | ~out_valid);
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);

  // Packet FSM: header serialisation, payload forwarding and the registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hdr_reg   <= '0;
      cnt       <= '0;
      eop_taken <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hdr_reg   <= hdr_fields;
            cnt       <= '0;
            eop_taken <= 1'b0;
            state     <= HDR;
            out_data  <= hdr_fields[HDR_BITS-1 -: AVL_SIZE];
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            out_eop   <= 1'b0;
            out_empty <= '0;
          end
        end

        HDR: begin
          if (xfer) begin
            hdr_reg <= hdr_shift;
            cnt     <= cnt + CNT_W'(1);
            out_sop <= 1'b0;
            if (cnt == LAST_HDR) begin
              // Header fully sent; payload starts from an empty output register.
              state     <= PAY;
              out_valid <= 1'b0;
            end else begin
              out_data <= hdr_shift[HDR_BITS-1 -: AVL_SIZE];
            end
          end
        end

        PAY: begin
          if (accept) begin
            out_data  <= in_data;
            out_eop   <= in_eop;
            out_empty <= in_empty;
            out_sop   <= 1'b0;
            out_valid <= 1'b1;
            if (in_eop) begin
              eop_taken <= 1'b1;
            end
          end else if (xfer) begin
            out_valid <= 1'b0;
            if (out_eop) begin
              // Last word of the packet has left; a new start is honoured from next cycle.
              state     <= IDLE;
              eop_taken <= 1'b0;
              out_eop   <= 1'b0;
              out_empty <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_encode_stream.sv
// tb_icmp_encode_stream: checks header insertion, framing and flow control on three configurations.
// Latency: stimulus driven 1 ns after rising edge, outputs sampled on falling edge.
// Backpressure: random and scripted out_ready stalls, random in_valid gaps.
module tb_icmp_encode_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  f_type, f_code;
  logic [15:0] f_cks, f_id, f_seq;

  // main instance: 16-bit bus, echo header (4 header words)
  logic        m_start, m_in_valid, m_in_eop, m_in_ready;
  logic        m_out_valid, m_out_sop, m_out_eop, m_out_ready, m_busy;
  logic [15:0] m_in_data, m_out_data;
  logic [0:0]  m_in_empty, m_out_empty;

  // instance A: 8-bit bus, plain header
  logic        a_start, a_in_valid, a_in_eop, a_in_ready;
  logic        a_out_valid, a_out_sop, a_out_eop, a_out_ready, a_busy;
  logic [7:0]  a_in_data, a_out_data;
  logic [0:0]  a_in_empty, a_out_empty;

  // instance C: 32-bit bus, echo header
  logic        c_start, c_in_valid, c_in_eop, c_in_ready;
  logic        c_out_valid, c_out_sop, c_out_eop, c_out_ready, c_busy;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_in_empty, c_out_empty;

  icmp_encode_stream #(.AVL_SIZE(16), .ECHO_HDR(1)) u_main (
    .clk(clk), .reset(reset), .start(m_start), .icmp_type(f_type), .code(f_code),
    .checksum(f_cks), .identifier(f_id), .icmp_sequence(f_seq),
    .in_data(m_in_data), .in_valid(m_in_valid), .in_eop(m_in_eop), .in_empty(m_in_empty),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid), .out_sop(m_out_sop),
    .out_eop(m_out_eop), .out_empty(m_out_empty), .out_ready(m_out_ready), .busy(m_busy));

  icmp_encode_stream #(.AVL_SIZE(8), .ECHO_HDR(0)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .icmp_type(f_type), .code(f_code),
    .checksum(f_cks), .identifier(f_id), .icmp_sequence(f_seq),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_eop(a_in_eop), .in_empty(a_in_empty),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_sop(a_out_sop),
    .out_eop(a_out_eop), .out_empty(a_out_empty), .out_ready(a_out_ready), .busy(a_busy));

  icmp_encode_stream #(.AVL_SIZE(32), .ECHO_HDR(1)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .icmp_type(f_type), .code(f_code),
    .checksum(f_cks), .identifier(f_id), .icmp_sequence(f_seq),
    .in_data(c_in_data), .in_valid(c_in_valid), .in_eop(c_in_eop), .in_empty(c_in_empty),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_sop(c_out_sop),
    .out_eop(c_out_eop), .out_empty(c_out_empty), .out_ready(c_out_ready), .busy(c_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  typedef logic [18:0] mword_t;   // {sop, eop, empty, data}
  mword_t      mq[$];
  mword_t      exp_q[$];
  int          m_idx = 0;
  bit          m_prev_stall = 0;
  logic [19:0] m_prev;

  always @(negedge clk) begin
    if (reset) begin
      m_prev_stall = 0;
      m_idx = 0;
    end else begin
      if (m_prev_stall)
        chk("hold_stable", {m_out_valid, m_out_sop, m_out_eop, m_out_empty, m_out_data}, m_prev);
      if (!m_busy) m_idx = 0;
      else if (m_idx < 4) chk("in_ready_in_hdr", m_in_ready, 0);
      else if (m_out_valid && !m_out_ready) chk("in_ready_stalled", m_in_ready, 0);
      if (m_out_valid && m_out_ready) begin
        mq.push_back({m_out_sop, m_out_eop, m_out_empty, m_out_data});
        m_idx++;
      end
      m_prev_stall = m_out_valid && !m_out_ready;
      m_prev = {m_out_valid, m_out_sop, m_out_eop, m_out_empty, m_out_data};
    end
  end

  logic [10:0] aq[$];
  bit a_after_eop = 0;
  always @(negedge clk) begin
    if (a_after_eop) begin
      chk("a_busy_after_eop", a_busy, 0);
      a_after_eop = 0;
    end
    if (!reset && a_out_valid && a_out_ready) begin
      aq.push_back({a_out_sop, a_out_eop, a_out_empty, a_out_data});
      if (a_out_eop) a_after_eop = 1;
    end
  end

  logic [35:0] cq[$];
  always @(negedge clk) begin
    if (!reset && c_out_valid && c_out_ready)
      cq.push_back({c_out_sop, c_out_eop, c_out_empty, c_out_data});
  end

  // ---------------- reference model ----------------
  logic [7:0]  mdl_t, mdl_c;
  logic [15:0] mdl_ck, mdl_id, mdl_sq;
  logic [15:0] pay[0:7];
  int          pay_n;
  logic        pay_empty;

  // Wire order: header bytes two per word, then payload words; sop first, eop/empty on last.
  task automatic build_exp();
    logic [7:0] hb[$];
    hb = '{mdl_t, mdl_c, mdl_ck[15:8], mdl_ck[7:0], mdl_id[15:8], mdl_id[7:0], mdl_sq[15:8], mdl_sq[7:0]};
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 0, 1'b0, 1'b0, hb[2*i], hb[2*i+1]});
    for (int i = 0; i < pay_n; i++)
      exp_q.push_back({1'b0, i == pay_n - 1, (i == pay_n - 1) ? pay_empty : 1'b0, pay[i]});
  endtask

  task automatic cmp_main(input string tag);
    chk($sformatf("%s_len", tag), mq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), mq[i], exp_q[i]);
  endtask

  // ---------------- main-instance drivers ----------------
  task automatic drain_main(input int rdy_pct, input bit poke);
    int cyc;
    bit poked;
    cyc = 0;
    poked = 0;
    while (cyc < 400) begin
      m_out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (!m_busy) break;
      if (poke && m_out_valid && m_out_ready && m_out_eop) begin
        m_start = 1'b1;
        poked = 1;
      end
      @(posedge clk); #1;
      m_start = 1'b0;
      cyc++;
    end
    chk("drain_busy", m_busy, 0);
    @(posedge clk); #1;
    m_start = 1'b0;
    m_out_ready = 1'b1;
    if (poked) begin
      @(negedge clk);
      chk("start_on_eop_ignored", m_busy, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_pkt(input int rdy_pct, input int vld_pct, input bit noise);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    f_type = mdl_t; f_code = mdl_c; f_cks = mdl_ck; f_id = mdl_id; f_seq = mdl_sq;
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    while (idx < pay_n && cyc < 400) begin
      if (noise) begin
        f_type = 8'($urandom); f_code = 8'($urandom); f_cks = 16'($urandom);
        f_id = 16'($urandom); f_seq = 16'($urandom);
        m_start = ($urandom_range(0, 3) == 0);
      end
      m_in_valid  = ($urandom_range(0, 99) < vld_pct);
      m_in_data   = pay[idx];
      m_in_eop    = (idx == pay_n - 1);
      m_in_empty  = m_in_eop ? pay_empty : 1'b0;
      m_out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (m_in_valid && m_in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    m_in_valid = 1'b0;
    m_start = 1'b0;
    chk("pay_accepted", idx, pay_n);
    drain_main(rdy_pct, noise);
  endtask

  typedef struct packed {
    logic [7:0]       t;
    logic [7:0]       c;
    logic [15:0]      ck;
    logic [15:0]      id;
    logic [15:0]      sq;
    logic [15:0]      p;
    logic             emp;
    logic [0:4][15:0] ew;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  apay[0:1];
    logic [10:0] a_exp[0:5];
    logic [35:0] c_exp[0:2];
    int idx;
    logic [0:3] pat;

    tbl[0] = '{8'h08, 8'h00, 16'hF7FF, 16'h1234, 16'h0001, 16'hABCD, 1'b0,
               {16'h0800, 16'hF7FF, 16'h1234, 16'h0001, 16'hABCD}};
    tbl[1] = '{8'h00, 8'h00, 16'hABCD, 16'hBEEF, 16'h0002, 16'hDE00, 1'b1,
               {16'h0000, 16'hABCD, 16'hBEEF, 16'h0002, 16'hDE00}};
    tbl[2] = '{8'h0B, 8'h01, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h5A5A, 1'b0,
               {16'h0B01, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h5A5A}};

    reset = 1'b1;
    f_type = '0; f_code = '0; f_cks = '0; f_id = '0; f_seq = '0;
    m_start = 0; m_in_valid = 0; m_in_eop = 0; m_in_empty = '0; m_in_data = '0; m_out_ready = 1;
    a_start = 0; a_in_valid = 0; a_in_eop = 0; a_in_empty = '0; a_in_data = '0; a_out_ready = 1;
    c_start = 0; c_in_valid = 0; c_in_eop = 0; c_in_empty = '0; c_in_data = '0; c_out_ready = 1;

    #12;
    chk("reset_out_valid", m_out_valid, 0);
    chk("reset_sop_eop", {m_out_sop, m_out_eop}, 0);
    chk("reset_busy_in_ready", {m_busy, m_in_ready}, 0);
    chk("reset_data_empty", {m_out_data, m_out_empty}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // table-driven single-payload packets on the 16-bit echo instance
    for (int v = 0; v < 3; v++) begin
      mdl_t = tbl[v].t; mdl_c = tbl[v].c; mdl_ck = tbl[v].ck; mdl_id = tbl[v].id; mdl_sq = tbl[v].sq;
      pay[0] = tbl[v].p; pay_n = 1; pay_empty = tbl[v].emp;
      mq.delete();
      drive_pkt(100, 100, 0);
      exp_q.delete();
      for (int i = 0; i < 5; i++)
        exp_q.push_back({i == 0, i == 4, (i == 4) ? tbl[v].emp : 1'b0, tbl[v].ew[i]});
      cmp_main($sformatf("tbl%0d", v));
    end

    // header stall pattern 1,0,0,1 then a 3-cycle payload stall
    mdl_t = 8'h08; mdl_c = 8'h00; mdl_ck = 16'h1111; mdl_id = 16'h2222; mdl_sq = 16'h3333;
    pay[0] = 16'hC0DE; pay[1] = 16'hF00D; pay_n = 2; pay_empty = 1'b1;
    build_exp();
    mq.delete();
    pat = 4'b1001;
    f_type = mdl_t; f_code = mdl_c; f_cks = mdl_ck; f_id = mdl_id; f_seq = mdl_sq;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    for (int k = 0; k < 40 && m_idx < 4; k++) begin
      m_out_ready = pat[k % 4];
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk("hdr_done", m_idx, 4);
    m_out_ready = 1'b1;
    m_in_valid = 1'b1; m_in_data = pay[0]; m_in_eop = 1'b0; m_in_empty = 1'b0;
    @(negedge clk);
    chk("pay_first_ready", m_in_ready, 1);
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    m_in_data = pay[1]; m_in_eop = 1'b1; m_in_empty = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pay_stall_in_ready", m_in_ready, 0);
      chk("pay_stall_data", {m_out_valid, m_out_data}, {1'b1, pay[0]});
      @(posedge clk); #1;
    end
    m_out_ready = 1'b1;
    @(negedge clk);
    chk("pay_resume_ready", m_in_ready, 1);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    drain_main(100, 0);
    cmp_main("stall");

    // randomized packets against the model, odd packets with field noise and stray starts
    for (int p = 0; p < 20; p++) begin
      mdl_t = 8'($urandom); mdl_c = 8'($urandom); mdl_ck = 16'($urandom);
      mdl_id = 16'($urandom); mdl_sq = 16'($urandom);
      pay_n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) pay[i] = 16'($urandom);
      pay_empty = 1'($urandom);
      build_exp();
      mq.delete();
      drive_pkt($urandom_range(40, 100), $urandom_range(30, 100), p[0]);
      cmp_main($sformatf("rnd%0d", p));
    end

    // asynchronous reset in the middle of the payload
    mdl_t = 8'h11; mdl_c = 8'h22; mdl_ck = 16'h3344; mdl_id = 16'h5566; mdl_sq = 16'h7788;
    pay[0] = 16'hAAAA; pay[1] = 16'hBBBB; pay[2] = 16'hCCCC; pay_n = 3;
    f_type = mdl_t; f_code = mdl_c; f_cks = mdl_ck; f_id = mdl_id; f_seq = mdl_sq;
    m_out_ready = 1'b1;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && m_idx < 5; k++) begin
      m_in_valid = 1'b1; m_in_data = pay[idx]; m_in_eop = (idx == 2); m_in_empty = 1'b0;
      @(negedge clk);
      if (m_in_valid && m_in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("reset_setup_reached_payload", m_idx, 5);
    m_in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", m_out_valid, 0);
    chk("async_rst_busy", m_busy, 0);
    chk("async_rst_in_ready", m_in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    @(posedge clk); #1;
    mdl_t = 8'h00; mdl_c = 8'h00; mdl_ck = 16'h0F0F; mdl_id = 16'hA5A5; mdl_sq = 16'h0009;
    pay[0] = 16'h1357; pay_n = 1; pay_empty = 1'b0;
    build_exp();
    drive_pkt(100, 100, 0);
    cmp_main("post_reset");

    // 8-bit plain header: 08 00 F7 FF AB CD
    apay[0] = 8'hAB; apay[1] = 8'hCD;
    a_exp[0] = {1'b1, 1'b0, 1'b0, 8'h08};
    a_exp[1] = {1'b0, 1'b0, 1'b0, 8'h00};
    a_exp[2] = {1'b0, 1'b0, 1'b0, 8'hF7};
    a_exp[3] = {1'b0, 1'b0, 1'b0, 8'hFF};
    a_exp[4] = {1'b0, 1'b0, 1'b0, 8'hAB};
    a_exp[5] = {1'b0, 1'b1, 1'b0, 8'hCD};
    aq.delete();
    f_type = 8'h08; f_code = 8'h00; f_cks = 16'hF7FF;
    a_out_ready = 1'b1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && idx < 2; k++) begin
      a_in_valid = 1'b1; a_in_data = apay[idx]; a_in_eop = (idx == 1); a_in_empty = 1'b0;
      @(negedge clk);
      if (a_in_valid && a_in_ready) idx++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    for (int k = 0; k < 40 && a_busy; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("a_len", aq.size(), 6);
    for (int i = 0; i < 6 && i < aq.size(); i++) chk($sformatf("a_w%0d", i), aq[i], a_exp[i]);

    // 32-bit echo header with one payload word, empty = 1
    c_exp[0] = {1'b1, 1'b0, 2'd0, 32'h0000ABCD};
    c_exp[1] = {1'b0, 1'b0, 2'd0, 32'h12340001};
    c_exp[2] = {1'b0, 1'b1, 2'd1, 32'hDEADBEEF};
    cq.delete();
    f_type = 8'h00; f_code = 8'h00; f_cks = 16'hABCD; f_id = 16'h1234; f_seq = 16'h0001;
    c_out_ready = 1'b1;
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && idx < 1; k++) begin
      c_in_valid = 1'b1; c_in_data = 32'hDEADBEEF; c_in_eop = 1'b1; c_in_empty = 2'd1;
      @(negedge clk);
      if (c_in_valid && c_in_ready) idx++;
      @(posedge clk); #1;
    end
    c_in_valid = 1'b0;
    for (int k = 0; k < 40 && c_busy; k++) begin
      @(posedge clk); #1;
    end
    chk("c_busy_done", c_busy, 0);
    chk("c_len", cq.size(), 3);
    for (int i = 0; i < 3 && i < cq.size(); i++) chk($sformatf("c_w%0d", i), cq[i], c_exp[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icmp_encode_stream.md
Name: icmp_encode_stream

Overview:
- Parametrised ICMP header inserter for the UDP/IP core transmit path.
- Latches ICMP header fields on a start pulse and emits them as the first words of an Avalon-ST-style stream.
- Then forwards the payload stream with ready/valid back-pressure.
- Adds over the earlier shift-register encoder: configurable bus width, optional 8-byte echo header (identifier/sequence), a handshake in both directions, and explicit packet framing.

Parameters:
- AVL_SIZE, 8, stream data width in bits; legal values 8, 16, 32.
- ECHO_HDR, 0, 0 = 4-byte header (type, code, checksum); 1 = 8-byte header (adds identifier, sequence).
- BYTE_SIZE, 8, bits per byte.
- HDR_BYTES, 4+4*ECHO_HDR, derived header length in bytes; not overridden.
- HDR_WORDS, HDR_BYTES*8/AVL_SIZE, derived header length in words.
- EMPTY_W, clog2(AVL_SIZE/8) (minimum 1), width of the empty field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches header fields and begins a packet (honoured in IDLE only).
- icmp_type  in  8  ICMP type.
- code  in  8  ICMP code.
- checksum  in  16  precomputed ICMP checksum.
- identifier  in  16  echo identifier (ignored when ECHO_HDR=0).
- sequence  in  16  echo sequence number (ignored when ECHO_HDR=0).
- in_data  in  AVL_SIZE  payload word, MSB = first byte.
- in_valid  in  1  payload word valid.
- in_eop  in  1  last payload word.
- in_empty  in  EMPTY_W  unused bytes in the last payload word.
- in_ready  out  1  payload accepted when in_valid & in_ready.
- out_data  out  AVL_SIZE  encoded stream word.
- out_valid  out  1  output word valid.
- out_sop  out  1  first header word.
- out_eop  out  1  last word of the packet.
- out_empty  out  EMPTY_W  unused bytes in the out_eop word.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE; header register 0; word counter 0; out_valid, out_sop, out_eop, in_ready, busy all 0; out_data and out_empty 0.
- Header register HDR_BYTES*8 bits, packed MSB-first:
  - {type, code, checksum}, or
  - {type, code, checksum, identifier, sequence}.
- Output is a registered skid-free stage: a word is transferred when out_valid & out_ready.
- While out_valid is high and out_ready is low, out_data, out_sop, out_eop and out_empty hold stable.
- IDLE:
  - in_ready = 0.
  - On start: latch all fields, counter = 0, go to HDR.
  - First header word (header register bits [HDR_BYTES*8-1 -: AVL_SIZE]) appears with out_valid = 1 and out_sop = 1 on the next cycle (latency 1 clk).
- HDR:
  - On each output transfer, shift the header register left by AVL_SIZE and increment the counter.
  - After the transfer of word HDR_WORDS-1, go to PAY.
  - out_sop is high only on word 0. in_ready = 0 throughout.
- PAY:
  - in_ready = out_ready | ~out_valid.
  - An accepted in_data, in_eop and in_empty is registered onto out_data, out_eop and out_empty with out_valid = 1 (1-clk latency).
  - If no input word is accepted and the current word transfers, out_valid drops to 0.
  - When an in_eop word is accepted, in_ready drops the next cycle. After that word transfers on the output, go to IDLE.
- out_empty is 0 on all header words.
- out_eop never appears on a header word; a packet always carries at least one payload word.
- start outside IDLE is ignored; latched fields are not disturbed.
- start coincident with the final eop transfer is ignored; start must be reissued once busy = 0.
- Asynchronous reset mid-packet returns everything to the reset values immediately. The partial packet is dropped with no eop; upstream is responsible for flushing.
- Counter width is clog2(HDR_WORDS)+1. It never wraps, because it is cleared on start.

Test Plan:
- AVL_SIZE=8, ECHO_HDR=0, type 0x08, code 0x00, checksum 0xF7FF, out_ready=1, 2 payload bytes 0xAB, 0xCD (eop on 0xCD) -> out bytes 08 00 F7 FF AB CD on consecutive cycles; sop on 08, eop on CD; busy low the cycle after the CD transfer.
- AVL_SIZE=32, ECHO_HDR=1, id 0x1234, seq 0x0001, type 0x00, code 0x00, checksum 0xABCD, payload 0xDEADBEEF with eop and in_empty=1 -> words 0x0000ABCD, 0x12340001, 0xDEADBEEF; out_empty=1 on the last word; sop on word 0 only.
- AVL_SIZE=16, out_ready toggling 1,0,0,1 during the header -> each word held stable while stalled; no word duplicated or lost; in_ready stays 0 until PAY.
- Payload back-pressure: out_ready=0 for 3 cycles in PAY -> in_ready=0 while the output word is pending; the first accepted word appears unchanged on out_data when out_ready returns.
- start pulsed again in HDR with different fields -> output header still uses the first fields; the new start is dropped.
- reset asserted in the middle of the payload -> out_valid, busy and in_ready go 0 asynchronously; a subsequent start produces a clean packet with sop.
